// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type and default sizes for the multi-port register file.
package regfile_pkg;
   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_t;
   localparam int RF_DATA_W = 16;
   localparam int RF_NREGS  = 8;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; reserve beats write-clear and bulk clear.
// REGFILE_BYPASS_EN: a port's busy output follows a same-cycle accepted write to its register.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = RF_NREGS,
   parameter int IDX_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_rsv_en,
   input  logic [IDX_W-1:0] i_rsv_idx,
   input  logic             i_clr_all,
   input  logic [IDX_W-1:0] i_rd_idx_a,
   input  logic [IDX_W-1:0] i_rd_idx_b,
   output logic             o_busy_a,
   output logic             o_busy_b
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   always_comb begin
      w_busy_nxt = i_clr_all ? '0 : r_busy;
      if (i_wr_en) w_busy_nxt[i_wr_idx] = 1'b0;
      if (i_rsv_en) w_busy_nxt[i_rsv_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_busy <= '0;
      else r_busy <= w_busy_nxt;

`ifdef REGFILE_BYPASS_EN
   // A forwarded write shows its post-edge busy state: 0 unless reserved in the same cycle.
   assign o_busy_a = (rst_n && i_wr_en && i_wr_idx == i_rd_idx_a) ? w_busy_nxt[i_rd_idx_a] : r_busy[i_rd_idx_a];
   assign o_busy_b = (rst_n && i_wr_en && i_wr_idx == i_rd_idx_b) ? w_busy_nxt[i_rd_idx_b] : r_busy[i_rd_idx_b];
`else
   assign o_busy_a = r_busy[i_rd_idx_a];
   assign o_busy_b = r_busy[i_rd_idx_b];
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 1W/2R register file with busy scoreboard and sequenced bulk clear.
// REGFILE_BYPASS_EN: forwards an accepted write's data to read ports in the same cycle.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int NREGS  = RF_NREGS,
   parameter int IDX_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [IDX_W-1:0]  writenum,
   input  logic [DATA_W-1:0] data_in,
   output logic              write_rdy,
   input  logic [IDX_W-1:0]  readnum_a,
   input  logic [IDX_W-1:0]  readnum_b,
   output logic [DATA_W-1:0] data_out_a,
   output logic [DATA_W-1:0] data_out_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              reserve,
   input  logic [IDX_W-1:0]  reservenum,
   input  logic              clear_req,
   output logic              clear_busy
);
   clr_state_t        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_regs [NREGS];
   logic              w_clr_run;
   logic              w_clr_start;
   logic              w_clr_last;
   logic              w_wr_en;
   logic              w_rsv_en;

   assign w_clr_run   = r_state == CLR_RUN;
   assign w_clr_start = clear_req && !w_clr_run;
   assign w_clr_last  = r_idx == IDX_W'(NREGS - 1);
   assign clear_busy  = w_clr_run;
   assign write_rdy   = !w_clr_run;
   assign w_wr_en     = write && write_rdy;
   assign w_rsv_en    = reserve && !w_clr_run;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= CLR_IDLE;
         r_idx   <= '0;
      end else if (w_clr_start) begin
         r_state <= CLR_RUN;
         r_idx   <= '0;
      end else if (w_clr_run) begin
         if (w_clr_last) r_state <= CLR_IDLE;
         else r_idx <= r_idx + 1'b1;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            if (w_clr_run && r_idx == IDX_W'(i)) r_regs[i] <= '0;
            else if (w_wr_en && writenum == IDX_W'(i)) r_regs[i] <= data_in;
      end

`ifdef REGFILE_BYPASS_EN
   assign data_out_a = (rst_n && w_wr_en && writenum == readnum_a) ? data_in : r_regs[readnum_a];
   assign data_out_b = (rst_n && w_wr_en && writenum == readnum_b) ? data_in : r_regs[readnum_b];
`else
   assign data_out_a = r_regs[readnum_a];
   assign data_out_b = r_regs[readnum_b];
`endif

   regfile_scoreboard #(.NREGS(NREGS), .IDX_W(IDX_W)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (writenum),
      .i_rsv_en   (w_rsv_en),
      .i_rsv_idx  (reservenum),
      .i_clr_all  (w_clr_start),
      .i_rd_idx_a (readnum_a),
      .i_rd_idx_b (readnum_b),
      .o_busy_a   (busy_a),
      .o_busy_b   (busy_b)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (honours REGFILE_BYPASS_EN).
module tb_regfile_mp;
   localparam int DW = 16;
   localparam int NR = 8;
   localparam int IW = 3;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0, write = 1'b0, reserve = 1'b0, clear_req = 1'b0;
   logic [IW-1:0] writenum = '0, readnum_a = '0, readnum_b = '0, reservenum = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out_a, data_out_b;
   logic          write_rdy, busy_a, busy_b, clear_busy;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
      .write_rdy(write_rdy), .readnum_a(readnum_a), .readnum_b(readnum_b),
      .data_out_a(data_out_a), .data_out_b(data_out_b), .busy_a(busy_a), .busy_b(busy_b),
      .reserve(reserve), .reservenum(reservenum), .clear_req(clear_req), .clear_busy(clear_busy)
   );

   typedef struct {
      string         tag;
      int            sig;
      logic [DW-1:0] exp;
   } exp_t;

   exp_t          q[$];
   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] m_reg [NR];
   logic          m_busy [NR];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] obs(input int sig);
      case (sig)
         0: obs = data_out_a;
         1: obs = data_out_b;
         2: obs = DW'(busy_a);
         3: obs = DW'(busy_b);
         4: obs = DW'(clear_busy);
         5: obs = DW'(write_rdy);
         default: obs = 'x;
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [DW-1:0] exp);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = exp;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         check(e.tag, obs(e.sig), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [IW-1:0] a, input logic [IW-1:0] b, input string tag);
      readnum_a = a;
      readnum_b = b;
      push({tag, "_da"}, 0, m_reg[a]);
      push({tag, "_db"}, 1, m_reg[b]);
      push({tag, "_ba"}, 2, DW'(m_busy[a]));
      push({tag, "_bb"}, 3, DW'(m_busy[b]));
      drain();
   endtask

   task automatic wr(input logic [IW-1:0] n, input logic [DW-1:0] d, input logic r);
      write = 1'b1;
      writenum = n;
      data_in = d;
      reserve = r;
      reservenum = n;
      tick();
      write = 1'b0;
      reserve = 1'b0;
      m_reg[n] = d;
      m_busy[n] = r;
   endtask

   task automatic start_clear();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_hi;
      for (int i = 0; i < NR; i++) begin
         m_reg[i] = '0;
         m_busy[i] = 1'b0;
      end
      #12;
      push("rst_cb", 4, '0);
      push("rst_rdy", 5, 16'd1);
      push("rst_da", 0, '0);
      push("rst_ba", 2, '0);
      drain();
      @(negedge clk) rst_n = 1'b1;
      tick();
      for (int i = 0; i < NR; i++) rd(IW'(i), IW'(NR - 1 - i), $sformatf("rst_r%0d", i));

      readnum_a = 3;
      write = 1'b1;
      writenum = 3;
      data_in = 16'hBEEF;
      push("wr3_same", 0, BYP ? 16'hBEEF : 16'h0000);
      drain();
      tick();
      write = 1'b0;
      m_reg[3] = 16'hBEEF;
      rd(3, 3, "wr3");

      reserve = 1'b1;
      reservenum = 5;
      tick();
      reserve = 1'b0;
      m_busy[5] = 1'b1;
      rd(5, 4, "rsv5");
      wr(5, 16'h1234, 1'b0);
      rd(5, 5, "wr5");
      wr(5, 16'h1234, 1'b1);
      rd(5, 5, "rsvwr5");

      reserve = 1'b1;
      reservenum = 6;
      write = 1'b1;
      writenum = 2;
      data_in = 16'h2222;
      tick();
      reserve = 1'b0;
      write = 1'b0;
      m_busy[6] = 1'b1;
      m_busy[2] = 1'b0;
      m_reg[2] = 16'h2222;
      rd(6, 2, "split");

      for (int i = 0; i < NR; i++) wr(IW'(i), DW'(16'h1111 * (i + 1)), 1'b0);
      reserve = 1'b1;
      reservenum = 5;
      tick();
      reserve = 1'b0;
      m_busy[5] = 1'b1;
      rd(5, 5, "pre_clr");
      start_clear();
      for (int c = 0; c < NR; c++) begin
         readnum_a = IW'(c);
         readnum_b = (c == 0) ? IW'(5) : IW'(c - 1);
         if (c == 2) begin
            write = 1'b1;
            writenum = 2;
            data_in = 16'hDEAD;
         end
         push($sformatf("clr%0d_cb", c), 4, 16'd1);
         push($sformatf("clr%0d_rdy", c), 5, 16'd0);
         push($sformatf("clr%0d_da", c), 0, m_reg[c]);
         push($sformatf("clr%0d_db", c), 1, m_reg[readnum_b]);
         push($sformatf("clr%0d_bb", c), 3, DW'(m_busy[readnum_b]));
         drain();
         tick();
         write = 1'b0;
         m_reg[c] = '0;
      end
      push("clr_done_cb", 4, '0);
      push("clr_done_rdy", 5, 16'd1);
      drain();
      for (int i = 0; i < NR; i++) rd(IW'(i), IW'(i), $sformatf("post_clr_r%0d", i));

      wr(0, 16'hAAAA, 1'b0);
      wr(7, 16'h7777, 1'b0);
      start_clear();
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      readnum_a = 7;
      push("mid_rst_cb", 4, '0);
      push("mid_rst_rdy", 5, 16'd1);
      push("mid_rst_r7", 0, '0);
      drain();
      @(negedge clk) rst_n = 1'b1;
      tick();
      for (int i = 0; i < NR; i++) rd(IW'(i), IW'(i), $sformatf("after_rst_r%0d", i));
      wr(4, 16'h4444, 1'b0);
      start_clear();
      n_hi = 0;
      for (int k = 0; k < 20 && clear_busy; k++) begin
         n_hi++;
         tick();
      end
      m_reg[4] = '0;
      check("clr2_len", DW'(n_hi), DW'(NR));
      rd(4, 0, "clr2_r4");

      wr(1, 16'h0101, 1'b0);
      reserve = 1'b1;
      reservenum = 1;
      tick();
      reserve = 1'b0;
      m_busy[1] = 1'b1;
      readnum_a = 1;
      write = 1'b1;
      writenum = 1;
      data_in = 16'hA5A5;
      push("byp_da", 0, BYP ? 16'hA5A5 : 16'h0101);
      push("byp_ba", 2, BYP ? 16'd0 : 16'd1);
      drain();
      tick();
      write = 1'b0;
      m_reg[1] = 16'hA5A5;
      m_busy[1] = 1'b0;
      rd(1, 1, "byp_after");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
